// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first.
// One addition takes WIDTH cycles in RUN, then a one-cycle done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, psum;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s, carry_nxt, last, load;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        s         = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nxt = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        last      = (cnt == CW'(WIDTH - 1));
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                // a start in DONE chains straight into the next addition
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                psum  <= {s, psum[WIDTH-1:1]};
                carry <= carry_nxt;
                cnt   <= cnt + 1'b1;
                // results only move on completion so they stay stable through RUN
                if (last) begin
                    sum  <= {s, psum[WIDTH-1:1]};
                    cout <= carry_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random bench for serial_adder; reference is plain a+b+cin.
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst, start, cin;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, cout;
    logic [WIDTH-1:0] sum;

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start one addition and follow it to its done pulse. disturb injects an
    // ignored start plus operand churn mid-run; hold checks sum/cout stability.
    task automatic do_op(input string tag, input logic [WIDTH-1:0] oa,
                         input logic [WIDTH-1:0] ob, input logic oc,
                         input bit disturb, input bit hold);
        logic [WIDTH:0]   exp;
        logic [WIDTH-1:0] held_sum;
        logic             held_cout;
        int               cyc;
        bit               busy_ok, hold_ok;
        exp       = {1'b0, oa} + {1'b0, ob} + {{WIDTH{1'b0}}, oc};
        held_sum  = sum;
        held_cout = cout;
        a = oa; b = ob; cin = oc; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".busy_after_start"}, 32'(busy), 32'd1);
        cyc     = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!done && cyc < 4 * WIDTH) begin
            if (!busy) busy_ok = 1'b0;
            if (hold && (sum !== held_sum || cout !== held_cout)) hold_ok = 1'b0;
            if (disturb && cyc == 2) begin
                a = 8'hAA; b = 8'hAA; cin = 1'b1; start = 1'b1;
            end else if (disturb) begin
                start = 1'b0;
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
                cin = 1'($urandom);
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        chk({tag, ".latency"}, 32'(cyc), 32'(WIDTH));
        chk({tag, ".busy_in_run"}, 32'(busy_ok), 32'd1);
        if (hold) chk({tag, ".hold"}, 32'(hold_ok), 32'd1);
        chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, ".result"}, 32'({cout, sum}), 32'(exp));
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rc;
        int               dcount;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.sum",  32'(sum),  32'd0);
        chk("reset.cout", 32'(cout), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle.done", 32'(done), 32'd0);

        do_op("add_05_03", 8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        do_op("add_00_00_c", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        do_op("ignore_start", 8'h12, 8'h34, 1'b0, 1'b1, 1'b0);
        chk("ignore_start.sum", 32'(sum), 32'h46);

        // reset in the middle of an addition
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.sum",  32'(sum),  32'd0);
        chk("midrst.cout", 32'(cout), 32'd0);

        // back-to-back: second start lands in the DONE cycle of the first
        do_op("b2b_first", 8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        do_op("b2b_second", 8'h01, 8'h01, 1'b0, 1'b0, 1'b1);

        // aborted run must not leave a stray done pulse
        rst = 1'b1;
        tick();
        a = 8'h0F; b = 8'h01; start = 1'b1; rst = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            if (done) dcount++;
            tick();
        end
        chk("midrst.no_done", 32'(dcount), 32'd0);

        for (int i = 0; i < 200; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            do_op("rand", ra, rb, rc, 1'b0, (i % 4) == 1);
            if ((i % 3) == 0) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
